// File: rtl/axis_sample_pacer.sv
// axis_sample_pacer
// Buffers a bursty AXI-Stream sample source in a small FIFO. It releases one
// sample every CLK_DIV clocks as a single-cycle tvalid strobe. This strobe sets
// the fixed sample rate of the downstream biquad, which has no tready of its own.
//
// Handshake: an input word is accepted on a rising edge where s_axis_tvalid
// and s_axis_tready are both high. s_axis_tready is registered and does not
// depend on s_axis_tvalid. The output side has no ready signal.
// m_axis_tvalid is a one-cycle strobe, and m_axis_tdata is valid only while
// that strobe is high. Between strobes, m_axis_tdata holds its last value.
module axis_sample_pacer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          enable,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  // Storage and state
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q,  count_d;
  logic                  tready_q, tready_d;
  logic [DW-1:0]         div_q,    div_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q,  tdata_d;
  logic                  underrun_q, underrun_d;

  // Per-cycle events
  logic                  tick;
  logic                  push;
  logic                  pop;
  logic                  empty;

  // Event decode. Pops only see the occupancy before this cycle's push, so a
  // word that arrives in a tick cycle cannot fall through in that same cycle.
  always_comb begin
    empty = (count_q == '0);
    tick  = enable && (div_q == DIV_LAST);
    push  = s_axis_tvalid && tready_q;
    pop   = tick && !empty;
  end

  // Sample-period divider: runs only while enabled and restarts from 0 on
  // every enable rise.
  always_comb begin
    div_d = div_q;
    if (!enable) begin
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // FIFO pointers and occupancy. Full and empty come from the count, so the
  // pointers can wrap freely modulo the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    tready_d = (count_d < DEPTH_C);
  end

  // Output strobe, held data and sticky underrun. Set beats clear.
  always_comb begin
    tvalid_d   = pop;
    tdata_d    = tdata_q;
    underrun_d = underrun_q;
    if (pop) begin
      tdata_d = mem_q[rd_ptr_q];
    end
    if (tick && empty) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  // FIFO storage has no reset. Entries are only read after they are written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_axis_tdata;
    end
  end

  // Control and output registers. An asynchronous reset drops the strobe at
  // once and discards any queued words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tready_q   <= 1'b0;
      div_q      <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tready_q   <= tready_d;
      div_q      <= div_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      underrun_q <= underrun_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign underrun      = underrun_q;
  assign fill_level    = count_q;

endmodule
